// File: rtl/multi_phase_traffic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_traffic_ctrl
// Brief    : N-phase adaptive signal controller with demand skipping and fail-safe
// Revision : 1.0
// ============================================================================
module multi_phase_traffic_ctrl #(
  parameter int NUM_PHASES     = 4,
  parameter int LVL_W          = 2,
  parameter int TIMER_W        = 16,
  parameter int MIN_GREEN      = 400,
  parameter int GREEN_STEP     = 200,
  parameter int MAX_GREEN      = 1600,
  parameter int YELLOW_TICKS   = 200,
  parameter int ALLRED_TICKS   = 100,
  parameter int FAILSAFE_TICKS = 800,
  parameter int STUCK_THRESH   = 30
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [NUM_PHASES*LVL_W-1:0]   congestion_level,
  input  logic [NUM_PHASES-1:0]         phase_req,
  input  logic                          fail_safe_en,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          green,
  output logic                          yellow,
  output logic                          all_red,
  output logic                          fail_safe_active,
  output logic [TIMER_W-1:0]            green_time_ticks,
  output logic [TIMER_W-1:0]            timer_remaining,
  output logic                          cycle_wrap
);

  localparam int c_PH_W  = $clog2(NUM_PHASES);
  localparam int c_SUM_W = TIMER_W + LVL_W;
  localparam int c_CNT_W = $clog2(STUCK_THRESH + 2);

  localparam logic [1:0] c_ST_GREEN  = 2'd0;
  localparam logic [1:0] c_ST_YELLOW = 2'd1;
  localparam logic [1:0] c_ST_ALLRED = 2'd2;

  logic [1:0]                   r_state;
  logic [1:0]                   w_state_next;
  logic [c_PH_W-1:0]            r_phase;
  logic [TIMER_W-1:0]           r_timer;
  logic [TIMER_W-1:0]           r_green_time;
  logic                         r_wrap;
  logic                         r_fail_safe;
  logic [c_CNT_W-1:0]           r_stuck_cnt;
  logic [NUM_PHASES*LVL_W-1:0]  r_cong_prev;

  logic                         w_expire;
  logic                         w_enter;
  logic                         w_stuck;
  logic [NUM_PHASES-1:0]        w_demand;
  logic [c_PH_W-1:0]            w_rr_next;
  logic [c_PH_W-1:0]            w_search_idx;
  logic [c_PH_W-1:0]            w_next_phase;
  logic [LVL_W-1:0]             w_lvl_next;
  logic [c_SUM_W-1:0]           w_green_sum;
  logic [TIMER_W-1:0]           w_green_len;

  assign w_expire = tick && (r_timer <= TIMER_W'(1));
  assign w_enter  = (w_state_next != r_state);
  assign w_stuck  = (r_stuck_cnt > c_CNT_W'(STUCK_THRESH));

  always_comb begin
    w_demand = '0;
    for (int p = 0; p < NUM_PHASES; p++)
      w_demand[p] = phase_req[p] | (|congestion_level[p*LVL_W +: LVL_W]);
  end

  assign w_rr_next = (int'(r_phase) == NUM_PHASES - 1) ? '0 : r_phase + c_PH_W'(1);

  // Scan from farthest to nearest so the nearest demanding phase wins; k=NUM_PHASES is the current phase.
  always_comb begin
    w_search_idx = w_rr_next;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      if (w_demand[(int'(r_phase) + k) % NUM_PHASES])
        w_search_idx = c_PH_W'((int'(r_phase) + k) % NUM_PHASES);
    end
  end

  assign w_next_phase = r_fail_safe ? w_rr_next : w_search_idx;
  assign w_lvl_next   = congestion_level[int'(w_next_phase)*LVL_W +: LVL_W];
  assign w_green_sum  = c_SUM_W'(MIN_GREEN) + c_SUM_W'(w_lvl_next) * c_SUM_W'(GREEN_STEP);

  always_comb begin
    if (r_fail_safe)
      w_green_len = TIMER_W'(FAILSAFE_TICKS);
    else if (w_green_sum > c_SUM_W'(MAX_GREEN))
      w_green_len = TIMER_W'(MAX_GREEN);
    else
      w_green_len = w_green_sum[TIMER_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_ALLRED;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_GREEN:  if (w_expire) w_state_next = c_ST_YELLOW;
      c_ST_YELLOW: if (w_expire) w_state_next = c_ST_ALLRED;
      c_ST_ALLRED: if (w_expire) w_state_next = c_ST_GREEN;
      default:     w_state_next = c_ST_ALLRED;
    endcase
  end

  // Output decode
  always_comb begin
    green   = 1'b0;
    yellow  = 1'b0;
    all_red = 1'b0;
    case (r_state)
      c_ST_GREEN:  green   = 1'b1;
      c_ST_YELLOW: yellow  = 1'b1;
      default:     all_red = 1'b1;
    endcase
  end

  // Interval timer, phase index and green length; everything loads on state entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer      <= TIMER_W'(ALLRED_TICKS);
      r_green_time <= TIMER_W'(MIN_GREEN);
      r_phase      <= c_PH_W'(NUM_PHASES - 1);
      r_wrap       <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_enter) begin
        case (w_state_next)
          c_ST_GREEN: begin
            r_timer      <= w_green_len;
            r_green_time <= w_green_len;
            r_phase      <= w_next_phase;
            r_wrap       <= (w_next_phase <= r_phase);
          end
          c_ST_YELLOW: r_timer <= TIMER_W'(YELLOW_TICKS);
          default:     r_timer <= TIMER_W'(ALLRED_TICKS);
        endcase
      end else if (tick && (r_timer > TIMER_W'(1))) begin
        r_timer <= r_timer - TIMER_W'(1);
      end
    end
  end

  // Stuck-bus monitor: any change re-samples immediately, equal samples count only on ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cong_prev <= '0;
      r_stuck_cnt <= '0;
      r_fail_safe <= 1'b0;
    end else begin
      if (congestion_level != r_cong_prev) begin
        r_cong_prev <= congestion_level;
        r_stuck_cnt <= '0;
      end else if (tick && (r_stuck_cnt != '1)) begin
        r_stuck_cnt <= r_stuck_cnt + c_CNT_W'(1);
      end
      r_fail_safe <= fail_safe_en | w_stuck;
    end
  end

  assign active_phase     = r_phase;
  assign fail_safe_active = r_fail_safe;
  assign green_time_ticks = r_green_time;
  assign timer_remaining  = r_timer;
  assign cycle_wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_traffic_ctrl.sv
`default_nettype none
// Directed bench for multi_phase_traffic_ctrl: expected greens are queued as stimulus is
// set up and popped as each green interval is observed.
module tb_multi_phase_traffic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [7:0]  congestion_level;
  logic [3:0]  phase_req;
  logic        fail_safe_en;
  logic [1:0]  active_phase;
  logic        green, yellow, all_red, fail_safe_active, cycle_wrap;
  logic [15:0] green_time_ticks, timer_remaining;

  logic [1:0]  lvl [4];
  assign congestion_level = {lvl[3], lvl[2], lvl[1], lvl[0]};

  typedef struct { int phase; int len; bit wrap; } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int tdiv   = 1;
  int tcnt   = 0;
  bit wiggle = 1'b1;

  always #5 clk = ~clk;

  multi_phase_traffic_ctrl #(
    .NUM_PHASES(4), .LVL_W(2), .TIMER_W(16), .MIN_GREEN(4), .GREEN_STEP(2),
    .MAX_GREEN(8), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .FAILSAFE_TICKS(5),
    .STUCK_THRESH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .congestion_level(congestion_level),
    .phase_req(phase_req), .fail_safe_en(fail_safe_en), .active_phase(active_phase),
    .green(green), .yellow(yellow), .all_red(all_red), .fail_safe_active(fail_safe_active),
    .green_time_ticks(green_time_ticks), .timer_remaining(timer_remaining),
    .cycle_wrap(cycle_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tcnt++;
    tick = (tcnt % tdiv == 0);
  endtask

  task automatic expect_green(input int p, input int l, input bit w);
    exp_t e;
    e.phase = p; e.len = l; e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_all_red"}, all_red, 1);
    chk({tag, "_green"}, green, 0);
    chk({tag, "_yellow"}, yellow, 0);
    chk({tag, "_phase"}, active_phase, 3);
    chk({tag, "_timer"}, timer_remaining, 1);
    chk({tag, "_green_time"}, green_time_ticks, 4);
    chk({tag, "_fail_safe"}, fail_safe_active, 0);
    chk({tag, "_wrap"}, cycle_wrap, 0);
  endtask

  // Observe one green (plus optional yellow/all-red tail) against the next queued entry.
  // on_kind: 1 assert fail_safe_en, 2 release it, 3 set lvl[on_p]=on_v, applied at green cycle on_c.
  task automatic run_green(input int on_c, input int on_kind, input int on_p, input int on_v,
                           input int chk_c, input int chk_v, input bit chk_prev, input bit tail);
    exp_t e;
    int n, c, y, a;
    logic [1:0] saved;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    saved = lvl[e.phase];
    n = 0;
    while (green !== 1'b1 && n < 200) begin step(); n++; end
    chk("green_start", green, 1);
    chk("phase", active_phase, e.phase);
    chk("green_time", green_time_ticks, e.len);
    chk("timer_entry", timer_remaining, e.len);
    chk("wrap_entry", cycle_wrap, e.wrap);
    chk("onehot", {green, yellow, all_red}, 3'b100);
    c = 0;
    while (green === 1'b1 && c < 100) begin
      c++;
      if (c == 2) chk("wrap_pulse_width", cycle_wrap, 0);
      if (chk_prev && c == chk_c - 1) chk("fail_safe_before", fail_safe_active, !chk_v);
      if (c == chk_c) chk("fail_safe_after", fail_safe_active, chk_v);
      if (c == on_c) begin
        case (on_kind)
          1:       fail_safe_en = 1'b1;
          2:       fail_safe_en = 1'b0;
          3:       lvl[on_p] = 2'(on_v);
          default: ;
        endcase
      end
      if (wiggle && c == 1) begin saved = lvl[e.phase]; lvl[e.phase] = saved ^ 2'b01; end
      if (wiggle && c == e.len * tdiv - 1) lvl[e.phase] = saved;
      step();
    end
    chk("green_len", c, e.len * tdiv);
    chk("yellow_follows", yellow, 1);
    if (tail) begin
      y = 0;
      while (yellow === 1'b1 && y < 100) begin step(); y++; end
      chk("yellow_len", y, 2 * tdiv);
      chk("allred_follows", all_red, 1);
      a = 0;
      while (all_red === 1'b1 && a < 100) begin step(); a++; end
      chk("allred_len", a, tdiv);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b1; fail_safe_en = 1'b0; phase_req = 4'b1111;
    lvl[0] = 2'd0; lvl[1] = 2'd1; lvl[2] = 2'd2; lvl[3] = 2'd3;
    repeat (3) step();
    check_reset_values("reset");
    rst_n = 1'b1;
    chk("release_allred", all_red, 1);
    step();
    chk("allred_one_tick", green, 1);

    // Level-scaled greens with clamp, all phases demanding
    expect_green(0, 4, 1); expect_green(1, 6, 0); expect_green(2, 8, 0); expect_green(3, 8, 0);
    repeat (4) run_green(0, 0, 0, 0, 0, 0, 0, 1);

    // Skip phases without demand
    phase_req = 4'b0101;
    for (int p = 0; p < 4; p++) lvl[p] = 2'd0;
    expect_green(0, 4, 1); expect_green(2, 4, 0); expect_green(0, 4, 1);
    expect_green(2, 4, 0); expect_green(0, 4, 1);
    repeat (5) run_green(0, 0, 0, 0, 0, 0, 0, 1);

    // No demand anywhere: round robin, tick every third cycle
    phase_req = 4'b0000;
    tdiv = 3; tcnt = 1; tick = 1'b0;
    expect_green(2, 4, 0); expect_green(3, 4, 0); expect_green(0, 4, 1);
    repeat (3) run_green(0, 0, 0, 0, 0, 0, 0, 1);
    tdiv = 1; tick = 1'b1;

    // Manual fail-safe mid-green of phase 1, then strict round robin
    phase_req = 4'b0001;
    expect_green(1, 4, 0);
    run_green(2, 1, 0, 0, 3, 1, 1, 1);
    expect_green(2, 5, 0); expect_green(3, 5, 0); expect_green(0, 5, 1); expect_green(1, 5, 0);
    repeat (4) run_green(0, 0, 0, 0, 0, 0, 0, 1);
    expect_green(2, 5, 0);
    run_green(1, 2, 0, 0, 2, 0, 1, 1);
    // Current phase re-served only when nothing else demands
    expect_green(0, 4, 1); expect_green(0, 4, 1);
    repeat (2) run_green(0, 0, 0, 0, 0, 0, 0, 1);

    // Stuck congestion bus forces fail-safe; a level change clears it
    wiggle = 1'b0;
    lvl[2] = 2'd1;
    expect_green(0, 4, 1);
    run_green(0, 0, 0, 0, 0, 0, 0, 1);
    expect_green(2, 6, 0);
    run_green(0, 0, 0, 0, 3, 1, 1, 1);
    expect_green(3, 5, 0);
    run_green(2, 3, 2, 0, 4, 0, 0, 1);
    wiggle = 1'b1;
    expect_green(0, 4, 1);
    run_green(0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of yellow
    step();
    chk("mid_yellow", yellow, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_reset");
    repeat (2) step();
    chk("reset_hold_allred", all_red, 1);
    rst_n = 1'b1;
    step();
    chk("restart_allred_one_tick", green, 1);
    expect_green(0, 4, 1);
    run_green(0, 0, 0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
